// File: rtl/beamform_delay_sum.sv
// Delay-and-sum beamformer: per-channel programmable sample delay, masked full-precision sum,
// and an I2S serialiser carrying the beam (left) and the beam or a monitor channel (right).
module beamform_delay_sum #(
    parameter int unsigned N_CH    = 8,
    parameter int unsigned DW      = 19,
    parameter int unsigned MAX_DLY = 15,
    parameter int unsigned DLY_W   = $clog2(MAX_DLY + 1),
    parameter int unsigned SUM_W   = DW + $clog2(N_CH),
    parameter int unsigned SLOT_W  = 32,
    parameter int unsigned SEL_W   = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lr_clk,
    input  logic [N_CH*DW-1:0]      pcm_in,
    input  logic                    pcm_valid,
    input  logic [N_CH*DLY_W-1:0]   delay_cfg,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic                    mon_en,
    input  logic [SEL_W-1:0]        mon_sel,
    output logic [SUM_W-1:0]        beam_out,
    output logic                    beam_valid,
    output logic                    i2s_sd
);

    localparam int unsigned DEPTH = MAX_DLY + 1;

    logic [DW-1:0]     mem_q [N_CH][DEPTH];
    logic [DLY_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DLY_W-1:0]  dly [N_CH];
    logic [DLY_W-1:0]  rd_ptr [N_CH];
    logic [DW-1:0]     tap [N_CH];
    logic [SUM_W-1:0]  sum_d, mon_d;
    logic [SUM_W-1:0]  beam_q, mon_q;
    logic              valid_q, mon_en_q;
    logic              ws_q, armed_q, boundary;
    logic [SLOT_W-1:0] sh_q, sh_d;

    // Delayed taps; delay 0 bypasses the buffer and uses the incoming sample.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            dly[k] = delay_cfg[k*DLY_W +: DLY_W];
            if (int'(dly[k]) > int'(MAX_DLY)) begin
                dly[k] = DLY_W'(MAX_DLY);
            end
            if (wr_ptr_q >= dly[k]) begin
                rd_ptr[k] = wr_ptr_q - dly[k];
            end else begin
                rd_ptr[k] = wr_ptr_q + DLY_W'(DEPTH) - dly[k];
            end
            tap[k] = (dly[k] == '0) ? pcm_in[k*DW +: DW] : mem_q[k][rd_ptr[k]];
            if (ch_mask[k]) begin
                sum_d = sum_d + SUM_W'($signed(tap[k]));
            end
        end
        mon_d    = SUM_W'($signed(tap[mon_sel]));
        wr_ptr_d = (wr_ptr_q == DLY_W'(MAX_DLY)) ? '0 : wr_ptr_q + DLY_W'(1);
    end

    // armed_q keeps the first cycle after reset from being mistaken for a slot boundary.
    assign boundary = armed_q && (ws_q != lr_clk);

    always_comb begin
        sh_d = {sh_q[SLOT_W-2:0], 1'b0};
        if (boundary) begin
            if (lr_clk && mon_en_q) begin
                sh_d = SLOT_W'($signed(mon_q));
            end else begin
                sh_d = SLOT_W'($signed(beam_q));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_CH; k++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[k][i] <= '0;
                end
            end
            wr_ptr_q <= '0;
            beam_q   <= '0;
            mon_q    <= '0;
            mon_en_q <= 1'b0;
            valid_q  <= 1'b0;
            ws_q     <= 1'b0;
            armed_q  <= 1'b0;
            sh_q     <= '0;
        end else begin
            valid_q <= pcm_valid;
            if (pcm_valid) begin
                for (int k = 0; k < N_CH; k++) begin
                    mem_q[k][wr_ptr_q] <= pcm_in[k*DW +: DW];
                end
                wr_ptr_q <= wr_ptr_d;
                beam_q   <= sum_d;
                mon_q    <= mon_d;
                mon_en_q <= mon_en;
            end
            ws_q    <= lr_clk;
            armed_q <= 1'b1;
            sh_q    <= sh_d;
        end
    end

    assign beam_out   = beam_q;
    assign beam_valid = valid_q;
    assign i2s_sd     = sh_q[SLOT_W-1];

endmodule
